// File: rtl/rv_exec_core_if.sv
// Instruction/result bus of rv_exec_core: valid/ready instruction fields in,
// result with a one-cycle completion strobe out.
interface rv_exec_core_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [11:0]      imm12;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             illegal;

  // Instruction source side.
  modport master (
    output in_valid, opcode, funct3, funct7b5, rd, rs1, rs2, imm12,
    input  in_ready, out, out_valid, illegal
  );

  // Execution core side.
  modport slave (
    input  in_valid, opcode, funct3, funct7b5, rd, rs1, rs2, imm12,
    output in_ready, out, out_valid, illegal
  );
endinterface

// File: rtl/rv_exec_core.sv
// Multi-cycle RV32I OP / OP-IMM execution core with an internal register
// file (x0 hard-wired to zero). Each instruction runs IDLE -> EXEC -> WRITE
// and completes with a one-cycle out_valid strobe.
module rv_exec_core #(
  parameter int WIDTH     = 32,
  parameter int NREGS     = 32,
  parameter int LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  rv_exec_core_if.slave        bus,
  output logic [LED_WIDTH-1:0] led
);

  localparam int SHW = $clog2(WIDTH);
  localparam int AW  = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  // Latched instruction fields
  logic [6:0]  opc_q;
  logic [2:0]  f3_q;
  logic        f7b5_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [11:0] imm_q;

  // Register file and pipeline results
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] res_q;
  logic             ill_q;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             illegal_q;

  logic             accept;
  logic             is_op, is_opimm, legal;
  logic [WIDTH-1:0] x_val, rs2_val, y_val, imm_sext, alu;
  logic [SHW-1:0]   shamt;

  // Indices beyond the implemented depth behave like x0: read 0, write dropped.
  function automatic logic in_range(input logic [4:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  function automatic logic [WIDTH-1:0] rd_reg(input logic [4:0] idx,
                                              input logic [WIDTH-1:0] val);
    return (idx != 5'd0 && in_range(idx)) ? val : '0;
  endfunction

  assign accept = bus.in_valid & bus.in_ready;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  // NOTE: state_d gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the core only takes a new instruction when idle
  always_comb begin
    bus.in_ready = 1'b0;
    if (state_q == S_IDLE) bus.in_ready = 1'b1;
  end

  // Capture all instruction fields on accept so the source may move on
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opc_q  <= '0;
      f3_q   <= '0;
      f7b5_q <= 1'b0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
    end else if (accept) begin
      opc_q  <= bus.opcode;
      f3_q   <= bus.funct3;
      f7b5_q <= bus.funct7b5;
      rd_q   <= bus.rd;
      rs1_q  <= bus.rs1;
      rs2_q  <= bus.rs2;
      imm_q  <= bus.imm12;
    end
  end

  // Operand selection and decode
  always_comb begin
    is_op    = (opc_q == OPC_OP);
    is_opimm = (opc_q == OPC_OPIMM);
    legal    = is_op | is_opimm;
    x_val    = rd_reg(rs1_q, regs_q[rs1_q[AW-1:0]]);
    rs2_val  = rd_reg(rs2_q, regs_q[rs2_q[AW-1:0]]);
    imm_sext = {{(WIDTH-12){imm_q[11]}}, imm_q};
    y_val    = is_op ? rs2_val : imm_sext;
    shamt    = y_val[SHW-1:0];
  end

  // ALU: funct7b5 selects SUB only for OP, and SRA/SRAI for both formats
  always_comb begin
    alu = '0;
    unique case (f3_q)
      3'b000: alu = (is_op && f7b5_q) ? x_val - y_val : x_val + y_val;
      3'b001: alu = x_val << shamt;
      3'b010: alu = {{(WIDTH-1){1'b0}}, ($signed(x_val) < $signed(y_val))};
      3'b011: alu = {{(WIDTH-1){1'b0}}, (x_val < y_val)};
      3'b100: alu = x_val ^ y_val;
      3'b101: alu = f7b5_q ? WIDTH'($signed(x_val) >>> shamt) : x_val >> shamt;
      3'b110: alu = x_val | y_val;
      3'b111: alu = x_val & y_val;
      default: alu = '0;
    endcase
  end

  // EXEC: register the result; illegal instructions produce 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q <= '0;
      ill_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      res_q <= legal ? alu : '0;
      ill_q <= ~legal;
    end
  end

  // WRITE: publish the result and strobe completion; out/illegal hold after
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q       <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_q == S_WRITE);
      if (state_q == S_WRITE) begin
        out_q     <= res_q;
        illegal_q <= ill_q;
      end
    end
  end

  // Register file write-back; x0, out-of-range and illegal writes are dropped
  // NOTE: the register file is reset because architectural registers must
  // read 0 after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == S_WRITE && !ill_q && rd_q != 5'd0 && in_range(rd_q)) begin
      regs_q[rd_q[AW-1:0]] <= res_q;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.illegal   = illegal_q;
  assign led           = out_q[LED_WIDTH-1:0];

endmodule

// File: tb/tb_rv_exec_core.sv
// Self-checking bench for rv_exec_core: table of instruction vectors with
// hand-derived results, a scoreboard queue of expected completions, and
// hand-written sequences for back-to-back issue and mid-instruction reset.
module tb_rv_exec_core;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;

  typedef struct {
    string       nm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] out;
    logic        ill;
    int          due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         prev_ov = 1'b0;
  exp_t       sb[$];
  exp_t       e;
  vec_t       tbl[$];

  rv_exec_core_if #(.WIDTH(32)) bus ();

  rv_exec_core #(.WIDTH(32), .NREGS(32), .LED_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .led   (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                              input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [11:0] imm,
                              input logic [31:0] exp, input logic ill);
    vec_t v;
    v.nm = nm; v.opc = opc; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1;
    v.rs2 = rs2; v.imm = imm; v.exp = exp; v.ill = ill;
    return v;
  endfunction

  // Present an instruction, wait (bounded) for acceptance, push expectation.
  task automatic issue(input vec_t v, input bit expect_result, output int acc);
    int n;
    exp_t x;
    @(negedge clk);
    bus.opcode   = v.opc;
    bus.funct3   = v.f3;
    bus.funct7b5 = v.f7;
    bus.rd       = v.rd;
    bus.rs1      = v.rs1;
    bus.rs2      = v.rs2;
    bus.imm12    = v.imm;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check({"accept_timeout_", v.nm}, 32'd0, 32'd1);
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (expect_result) begin
      x.nm = v.nm; x.out = v.exp; x.ill = v.ill; x.due = acc + 2;
      sb.push_back(x);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.opcode   = $urandom;
    bus.rd       = $urandom;
    bus.imm12    = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_empty", sb.size(), 0);
  endtask

  // Completion monitor: compare each strobe against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.out_valid) begin
        check("ov_single_cycle", {31'd0, prev_ov}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.nm, "_out"}, bus.out, e.out);
          check({e.nm, "_illegal"}, {31'd0, bus.illegal}, {31'd0, e.ill});
          check({e.nm, "_led"}, {24'd0, led}, {24'd0, e.out[7:0]});
          check({e.nm, "_latency"}, cyc, e.due);
        end
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, last;
    vec_t v;

    bus.in_valid = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
    bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm12 = '0;

    tbl.push_back(mk("addi_x1_5",     OPI, 3'b000, 0, 1,  0, 0, 12'd5,   32'h0000_0005, 0));
    tbl.push_back(mk("addi_x2_m3",    OPI, 3'b000, 0, 2,  0, 0, 12'hFFD, 32'hFFFF_FFFD, 0));
    tbl.push_back(mk("add_x3",        OP,  3'b000, 0, 3,  1, 2, 12'd0,   32'h0000_0002, 0));
    tbl.push_back(mk("sub_x4",        OP,  3'b000, 1, 4,  1, 2, 12'd0,   32'h0000_0008, 0));
    tbl.push_back(mk("slt_x5",        OP,  3'b010, 0, 5,  2, 1, 12'd0,   32'h0000_0001, 0));
    tbl.push_back(mk("sltu_x6",       OP,  3'b011, 0, 6,  2, 1, 12'd0,   32'h0000_0000, 0));
    tbl.push_back(mk("srai_x7",       OPI, 3'b101, 1, 7,  2, 0, 12'h401, 32'hFFFF_FFFE, 0));
    tbl.push_back(mk("srli_x8",       OPI, 3'b101, 0, 8,  2, 0, 12'h01C, 32'h0000_000F, 0));
    tbl.push_back(mk("addi_x10_33",   OPI, 3'b000, 0, 10, 0, 0, 12'd33,  32'h0000_0021, 0));
    tbl.push_back(mk("sll_by33",      OP,  3'b001, 0, 11, 1, 10, 12'd0,  32'h0000_000A, 0));
    tbl.push_back(mk("addi_x0_7",     OPI, 3'b000, 0, 0,  0, 0, 12'd7,   32'h0000_0007, 0));
    tbl.push_back(mk("add_x9_x0",     OP,  3'b000, 0, 9,  0, 0, 12'd0,   32'h0000_0000, 0));
    tbl.push_back(mk("illegal_03",    7'h03, 3'b000, 0, 1, 0, 0, 12'd9,  32'h0000_0000, 1));
    tbl.push_back(mk("x1_kept",       OP,  3'b000, 0, 12, 1, 0, 12'd0,   32'h0000_0005, 0));
    tbl.push_back(mk("xor",           OP,  3'b100, 0, 13, 1, 2, 12'd0,   32'hFFFF_FFF8, 0));
    tbl.push_back(mk("or",            OP,  3'b110, 0, 14, 1, 2, 12'd0,   32'hFFFF_FFFD, 0));
    tbl.push_back(mk("and",           OP,  3'b111, 0, 15, 1, 2, 12'd0,   32'h0000_0005, 0));
    tbl.push_back(mk("addi_f7_ign",   OPI, 3'b000, 1, 16, 1, 0, 12'hFFF, 32'h0000_0004, 0));
    tbl.push_back(mk("slti",          OPI, 3'b010, 0, 17, 2, 0, 12'hFFE, 32'h0000_0001, 0));
    tbl.push_back(mk("sltiu",         OPI, 3'b011, 0, 18, 1, 0, 12'hFFF, 32'h0000_0001, 0));
    tbl.push_back(mk("xori",          OPI, 3'b100, 0, 19, 1, 0, 12'h800, 32'hFFFF_F805, 0));
    tbl.push_back(mk("andi",          OPI, 3'b111, 0, 20, 2, 0, 12'h0F0, 32'h0000_00F0, 0));
    tbl.push_back(mk("sra",           OP,  3'b101, 1, 21, 2, 1, 12'd0,   32'hFFFF_FFFF, 0));
    tbl.push_back(mk("srl",           OP,  3'b101, 0, 22, 2, 1, 12'd0,   32'h07FF_FFFF, 0));

    // Reset state, observed while reset is held
    reset = 1'b0;
    #12;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out",       bus.out,                32'd0);
    check("rst_illegal",   {31'd0, bus.illegal},   32'd0);
    check("rst_led",       {24'd0, led},           32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven single instructions with idle gaps
    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i], 1'b1, acc);
      idle();
      drain();
    end
    check("illegal_hold_after", {31'd0, bus.illegal}, 32'd0);

    // Back-to-back with in_valid held high: dependent chain
    v = mk("b2b_0", OPI, 3'b000, 0, 23, 0, 0, 12'd1, 32'd1, 0);
    issue(v, 1'b1, last);
    v = mk("b2b_1", OPI, 3'b000, 0, 24, 23, 0, 12'd2, 32'd3, 0);
    issue(v, 1'b1, acc);
    check("b2b_gap1", acc - last, 32'd3);
    last = acc;
    v = mk("b2b_2", OP, 3'b000, 0, 25, 24, 24, 12'd0, 32'd6, 0);
    issue(v, 1'b1, acc);
    check("b2b_gap2", acc - last, 32'd3);
    last = acc;
    v = mk("b2b_3", OP, 3'b000, 1, 26, 25, 23, 12'd0, 32'd5, 0);
    issue(v, 1'b1, acc);
    check("b2b_gap3", acc - last, 32'd3);
    idle();
    drain();

    // Reset during EXEC aborts the instruction
    v = mk("abort_addi", OPI, 3'b000, 0, 1, 0, 0, 12'd9, 32'd9, 0);
    issue(v, 1'b0, acc);
    #2;
    reset = 1'b0;
    #1;
    check("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("abort_out_valid_hold", {31'd0, bus.out_valid}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_out", bus.out, 32'd0);
    v = mk("x1_after_abort", OP, 3'b000, 0, 9, 1, 0, 12'd0, 32'd0, 0);
    issue(v, 1'b1, acc);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
